regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-write register file with a write-through bypass and a per-register busy scoreboard.
//  Serves as the datapath GPR bank. Two combinational read ports feed the ALU.
//  Port A is the writeback port. Port B writes the dedicated special register (SPEC_REG, e.g. R15 product-high/remainder).
//  The scoreboard tracks in-flight destinations and produces the issue stall.
// PARAMETERS
//  DATA_W    16   register width
//  NREGS     16   number of registers (power of 2, >=4)
//  ADDR_W    $clog2(NREGS)  register address width (derived)
//  SPEC_REG  15   index written by port B and exported on spec_data
//  ZERO_REG  1    1: register 0 reads 0, ignores writes, is never busy
//  BYPASS    1    1: same-cycle write data forwarded to read ports
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-low
//  rd_addr1     in   ADDR_W   read port 1 address
//  rd_addr2     in   ADDR_W   read port 2 address
//  rd_data1     out  DATA_W   read port 1 data (combinational)
//  rd_data2     out  DATA_W   read port 2 data (combinational)
//  spec_data    out  DATA_W   current value of SPEC_REG (bypassed if BYPASS)
//  we_a         in   1        port A write enable
//  wa_addr      in   ADDR_W   port A write address
//  wa_data      in   DATA_W   port A write data
//  we_b         in   1        port B write enable (target fixed to SPEC_REG)
//  wb_data      in   DATA_W   port B write data
//  issue_valid  in   1        issue request: srcs rd_addr1/2, destination issue_dst
//  issue_dst    in   ADDR_W   destination register of issuing instruction
//  issue_ack    out  1        issue accepted this cycle (= issue_valid & ~stall)
//  stall        out  1        issue blocked by RAW/WAW hazard
//  wr_conflict  out  1        sticky: we_a and we_b both hit SPEC_REG in one cycle
// BEHAVIOUR
//  Reset (rst=0, async): all registers 0; busy[] all 0; wr_conflict 0. Outputs are then rd_data*=0, spec_data=0, stall=0, issue_ack=0.
//  Writes are registered on the rising clk edge. Reads are combinational (latency 0).
//  Bypass (BYPASS=1): if we_a & wa_addr==rd_addrN, rd_dataN=wa_data. If we_b & rd_addrN==SPEC_REG, rd_dataN=wb_data (B beats A).
//  BYPASS=0: reads return the pre-edge register contents.
//  Both ports hitting SPEC_REG in one cycle: port B value stored, A dropped. wr_conflict set at the edge, held until reset.
//  ZERO_REG=1: writes to reg 0 discarded, reads of reg 0 return 0, never bypassed, never busy.
//  Scoreboard: busy[NREGS], one bit per register.
//   Accepted issue sets busy[issue_dst] at the edge. A port-A write clears busy[wa_addr] at the same edge.
//   Port B never touches busy.
//   Issue and writeback to the same register in one cycle: busy ends 1 (newer producer wins).
//   eff_busy[r] = busy[r] & ~(we_a & wa_addr==r). Same-cycle writeback resolves the hazard via bypass.
//   stall = issue_valid & (eff_busy[rd_addr1] | eff_busy[rd_addr2] | eff_busy[issue_dst]).
//   A stalled issue leaves busy unchanged. The requester holds its inputs and retries.
//  Reset mid-operation: all in-flight state (busy, data, conflict flag) is lost immediately, asynchronously.
//  X-safety: address bits above NREGS are impossible (power-of-2 depth). No other out-of-range case exists.
// STRUCTURE
//  Shared package dp_pkg holds DATA_W/NREGS defaults, reg_addr_t typedef and SPEC_REG constant, shared with decoder/ALU.
//  Sub-module regfile_scoreboard (busy bits, eff_busy, stall/ack) instantiated once.
//  The storage array, bypass muxes and conflict flag stay in regfile_sb.
// TESTING
//  Reset: assert rst=0 mid-cycle -> rd_data1/2=0 and stall=0 immediately; busy cleared; wr_conflict=0.
//  Write/bypass: we_a=1, wa_addr=3, wa_data=16'h7B18, rd_addr1=3 -> rd_data1=7B18 same cycle (BYPASS=1); BYPASS=0 -> 0000 until next cycle.
//  Conflict: we_a=1, wa_addr=15, wa_data=1111, we_b=1, wb_data=2222 -> R15=2222 after edge, wr_conflict=1 until reset.
//  RAW stall: issue dst=5 accepted; next cycle issue src1=5 -> stall=1, issue_ack=0. Writeback wa_addr=5 same cycle -> stall=0, rd_data1=wa_data.
//  WAW/same-cycle: issue dst=7 while we_a writes 7 -> busy[7]=1 after edge; later issue src=7 stalls.
//  Zero reg: we_a to reg 0 with FFFF -> rd_data of reg 0 stays 0000; issue dst=0 never stalls a following reader.

Source files
------------

// File: rtl/dp_pkg.sv
// Datapath-wide defaults shared by the register file, decoder and ALU.
// Holds the default widths, the register address type and the special-register index.
package dp_pkg;

    localparam int DP_DATA_W   = 16;
    localparam int DP_NREGS    = 16;
    localparam int DP_ADDR_W   = $clog2(DP_NREGS);
    localparam int DP_SPEC_REG = 15;

    typedef logic [DP_ADDR_W-1:0] reg_addr_t;
    typedef logic [DP_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the GPR bank: one bit per register marks an in-flight
// producer. Issue is blocked on RAW/WAW hazards unless writeback resolves them this cycle.
module regfile_scoreboard
    import dp_pkg::*;
#(
    parameter int NREGS    = DP_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_addr,
    output logic              stall,
    output logic              issue_ack
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] eff_busy;

    // A writeback landing this cycle is forwarded by the bypass, so it no longer blocks.
    always_comb begin
        eff_busy = busy;
        if (we_a) begin
            eff_busy[wa_addr] = 1'b0;
        end
    end

    assign stall     = issue_valid & (eff_busy[src1] | eff_busy[src2] | eff_busy[issue_dst]);
    assign issue_ack = issue_valid & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            // NOTE: later non-blocking assignments to the same bit win, so the newer
            // producer (issue) overrides a same-cycle writeback clear.
            if (we_a) begin
                busy[wa_addr] <= 1'b0;
            end
            if (issue_ack) begin
                busy[issue_dst] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                busy[0] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// GPR bank with two combinational read ports, writeback port A, special-register
// port B, optional write-through bypass and the issue scoreboard.
module regfile_sb
    import dp_pkg::*;
#(
    parameter int DATA_W   = DP_DATA_W,
    parameter int NREGS    = DP_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int SPEC_REG = DP_SPEC_REG,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] spec_data,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              we_b,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              issue_ack,
    output logic              stall,
    output logic              wr_conflict
);

    localparam logic [ADDR_W-1:0] SPEC_ADDR = ADDR_W'(SPEC_REG);
    localparam int                NPORTS    = 3;

    logic [DATA_W-1:0] regs [NREGS];
    logic              a_hit;
    logic [ADDR_W-1:0] port_addr [NPORTS];
    logic [DATA_W-1:0] port_data [NPORTS];

    assign a_hit = we_a && !((ZERO_REG != 0) && (wa_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register contents are architecturally zero after reset, so
            // the array is reset here rather than left to a RAM macro.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            wr_conflict <= 1'b0;
        end else begin
            if (a_hit) begin
                regs[wa_addr] <= wa_data;
            end
            // Port B is assigned last so it takes SPEC_REG when both ports target it.
            if (we_b) begin
                regs[SPEC_ADDR] <= wb_data;
            end
            if (we_a && we_b && (wa_addr == SPEC_ADDR)) begin
                wr_conflict <= 1'b1;
            end
        end
    end

    // Ports 0/1 are the ALU reads; port 2 is the fixed SPEC_REG export.
    assign port_addr[0] = rd_addr1;
    assign port_addr[1] = rd_addr2;
    assign port_addr[2] = SPEC_ADDR;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            port_data[p] = regs[port_addr[p]];
            if ((BYPASS != 0) && we_a && (wa_addr == port_addr[p])) begin
                port_data[p] = wa_data;
            end
            if ((BYPASS != 0) && we_b && (port_addr[p] == SPEC_ADDR)) begin
                port_data[p] = wb_data;
            end
            if ((ZERO_REG != 0) && (port_addr[p] == '0)) begin
                port_data[p] = '0;
            end
        end
    end

    assign rd_data1  = port_data[0];
    assign rd_data2  = port_data[1];
    assign spec_data = port_data[2];

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_dst  (issue_dst),
        .src1       (rd_addr1),
        .src2       (rd_addr2),
        .we_a       (we_a),
        .wa_addr    (wa_addr),
        .stall      (stall),
        .issue_ack  (issue_ack)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb: a bypassing instance plus a BYPASS=0 twin
// share stimulus; expectations go through a queue between drive and sample.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wa_addr, issue_dst;
    logic [15:0] wa_data, wb_data;
    logic        we_a, we_b, issue_valid;

    logic [15:0] rd_data1, rd_data2, spec_data;
    logic        issue_ack, stall, wr_conflict;
    logic [15:0] nb_rd_data1, nb_rd_data2, nb_spec_data;
    logic        nb_issue_ack, nb_stall, nb_wr_conflict;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .spec_data(spec_data),
        .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
        .we_b(we_b), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .issue_ack(issue_ack), .stall(stall), .wr_conflict(wr_conflict)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2), .spec_data(nb_spec_data),
        .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
        .we_b(we_b), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .issue_ack(nb_issue_ack), .stall(nb_stall), .wr_conflict(nb_wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we_a;
        logic [3:0]  wa_addr;
        logic [15:0] wa_data;
        logic        we_b;
        logic [15:0] wb_data;
        logic [3:0]  rd1;
        logic [3:0]  rd2;
        logic        iv;
        logic [3:0]  idst;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic [15:0] e_spec;
        logic        e_stall;
        logic        e_ack;
        logic        e_conf;
        logic [15:0] e_nb1;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        we_a = 1'b0; wa_addr = '0; wa_data = '0;
        we_b = 1'b0; wb_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        issue_valid = 1'b0; issue_dst = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        // we_a wa  wa_data  we_b wb_data rd1 rd2 iv dst | rd1 rd2 spec stall ack conf nb_rd1
        vecs[0]  = '{1, 3,  16'h7B18, 0, 16'h0000, 3,  0, 0, 0,  16'h7B18, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[1]  = '{0, 0,  16'h0000, 0, 16'h0000, 3,  3, 0, 0,  16'h7B18, 16'h7B18, 16'h0000, 0, 0, 0, 16'h7B18};
        vecs[2]  = '{1, 15, 16'h1111, 1, 16'h2222, 15, 3, 0, 0,  16'h2222, 16'h7B18, 16'h2222, 0, 0, 0, 16'h0000};
        vecs[3]  = '{0, 0,  16'h0000, 0, 16'h0000, 15, 0, 0, 0,  16'h2222, 16'h0000, 16'h2222, 0, 0, 1, 16'h2222};
        vecs[4]  = '{1, 0,  16'hFFFF, 0, 16'h0000, 0, 15, 0, 0,  16'h0000, 16'h2222, 16'h2222, 0, 0, 1, 16'h0000};
        vecs[5]  = '{0, 0,  16'h0000, 0, 16'h0000, 0,  0, 0, 0,  16'h0000, 16'h0000, 16'h2222, 0, 0, 1, 16'h0000};
        vecs[6]  = '{0, 0,  16'h0000, 0, 16'h0000, 1,  2, 1, 5,  16'h0000, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[7]  = '{0, 0,  16'h0000, 0, 16'h0000, 5,  2, 1, 6,  16'h0000, 16'h0000, 16'h2222, 1, 0, 1, 16'h0000};
        vecs[8]  = '{1, 5,  16'hABCD, 0, 16'h0000, 5,  2, 1, 6,  16'hABCD, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[9]  = '{0, 0,  16'h0000, 0, 16'h0000, 5,  6, 1, 8,  16'hABCD, 16'h0000, 16'h2222, 1, 0, 1, 16'hABCD};
        vecs[10] = '{1, 7,  16'h7777, 0, 16'h0000, 1,  2, 1, 7,  16'h0000, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[11] = '{0, 0,  16'h0000, 0, 16'h0000, 7,  1, 1, 9,  16'h7777, 16'h0000, 16'h2222, 1, 0, 1, 16'h7777};
        vecs[12] = '{0, 0,  16'h0000, 0, 16'h0000, 1,  2, 1, 0,  16'h0000, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[13] = '{0, 0,  16'h0000, 0, 16'h0000, 0,  0, 1, 10, 16'h0000, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[14] = '{0, 0,  16'h0000, 0, 16'h0000, 1,  1, 1, 6,  16'h0000, 16'h0000, 16'h2222, 1, 0, 1, 16'h0000};
        vecs[15] = '{0, 0,  16'h0000, 0, 16'h0000, 6,  0, 0, 0,  16'h0000, 16'h0000, 16'h2222, 0, 0, 1, 16'h0000};
        vecs[16] = '{0, 0,  16'h0000, 0, 16'h0000, 1,  2, 1, 15, 16'h0000, 16'h0000, 16'h2222, 0, 1, 1, 16'h0000};
        vecs[17] = '{0, 0,  16'h0000, 1, 16'h3333, 15, 1, 1, 11, 16'h3333, 16'h0000, 16'h3333, 1, 0, 1, 16'h2222};
        vecs[18] = '{0, 0,  16'h0000, 0, 16'h0000, 15, 0, 0, 0,  16'h3333, 16'h0000, 16'h3333, 0, 0, 1, 16'h3333};

        drive_idle();
        rst = 1'b0;
        #12;
        check("reset_rd1",   32'(rd_data1), 32'h0);
        check("reset_rd2",   32'(rd_data2), 32'h0);
        check("reset_spec",  32'(spec_data), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_ack",   32'(issue_ack), 32'h0);
        check("reset_conf",  32'(wr_conflict), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            we_a = vecs[i].we_a; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            we_b = vecs[i].we_b; wb_data = vecs[i].wb_data;
            rd_addr1 = vecs[i].rd1; rd_addr2 = vecs[i].rd2;
            issue_valid = vecs[i].iv; issue_dst = vecs[i].idst;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("queue_empty", 32'(i), 32'hFFFF_FFFF);
            end else begin
                v = exp_q.pop_front();
                check($sformatf("v%0d_rd1", i),   32'(rd_data1),    32'(v.e_rd1));
                check($sformatf("v%0d_rd2", i),   32'(rd_data2),    32'(v.e_rd2));
                check($sformatf("v%0d_spec", i),  32'(spec_data),   32'(v.e_spec));
                check($sformatf("v%0d_stall", i), 32'(stall),       32'(v.e_stall));
                check($sformatf("v%0d_ack", i),   32'(issue_ack),   32'(v.e_ack));
                check($sformatf("v%0d_conf", i),  32'(wr_conflict), 32'(v.e_conf));
                check($sformatf("v%0d_nb_rd1", i), 32'(nb_rd_data1), 32'(v.e_nb1));
            end
        end

        // Mid-cycle asynchronous reset while R7 is busy and the conflict flag is set.
        @(posedge clk);
        #1;
        drive_idle();
        rd_addr1 = 4'd7; rd_addr2 = 4'd3; issue_valid = 1'b1; issue_dst = 4'd12;
        #1;
        check("pre_rst_stall", 32'(stall), 32'h1);
        check("pre_rst_rd1",   32'(rd_data1), 32'h7777);
        check("pre_rst_conf",  32'(wr_conflict), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_rd1",   32'(rd_data1), 32'h0);
        check("async_rst_rd2",   32'(rd_data2), 32'h0);
        check("async_rst_spec",  32'(spec_data), 32'h0);
        check("async_rst_stall", 32'(stall), 32'h0);
        check("async_rst_conf",  32'(wr_conflict), 32'h0);
        issue_valid = 1'b0;
        #1;
        check("async_rst_ack", 32'(issue_ack), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Previously busy registers must issue freely after reset.
        @(posedge clk);
        #1;
        rd_addr1 = 4'd7; rd_addr2 = 4'd6; issue_valid = 1'b1; issue_dst = 4'd10;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 32'h0);
        check("post_rst_ack",   32'(issue_ack), 32'h1);
        check("post_rst_rd1",   32'(rd_data1), 32'h0);
        check("post_rst_conf",  32'(wr_conflict), 32'h0);
        @(posedge clk);
        #1;
        drive_idle();
        rd_addr1 = 4'd15; issue_valid = 1'b1; issue_dst = 4'd10;
        @(negedge clk);
        check("waw_after_rst_stall", 32'(stall), 32'h1);
        check("post_rst_r15",        32'(rd_data1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
